page_walker: RTL and testbench

- Two-level page-table walk controller that sequences the single-port word-addressed ram for address translation.
- Accepts a 32-bit virtual address and issues the page-directory entry (PDE) read, then the page-table entry (PTE) read.
- Returns a 32-bit physical address or a not-present fault.
- Holds a small fully-associative TLB so repeat translations skip memory; sits between the fetch/load-store front end and ram.

---
 rtl/page_walk_pkg.sv | 26 ++
 rtl/pw_tlb.sv | 62 ++++++
 rtl/page_walker.sv | 135 +++++++++++++
 tb/tb_page_walker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/page_walk_pkg.sv
// Shared types and constants for the two-level page-table walker and its TLB.
package page_walk_pkg;

  localparam int VPN_DIR_HI = 31;
  localparam int VPN_DIR_LO = 22;
  localparam int VPN_TBL_HI = 21;
  localparam int VPN_TBL_LO = 12;
  localparam int PAGE_OFF_W = 12;
  localparam int PPN_W      = 20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PDE_RD  = 3'd1,
    PDE_CHK = 3'd2,
    PTE_RD  = 3'd3,
    PTE_CHK = 3'd4,
    RESP    = 3'd5
  } pw_state_e;

  typedef struct packed {
    logic             valid;
    logic [PPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/pw_tlb.sv
// Fully-associative translation cache: combinational lookup, single install port,
// flush, and lowest-free-then-round-robin replacement.
module pw_tlb
  import page_walk_pkg::*;
#(
  parameter int TLB_ENTRIES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PPN_W-1:0] lookup_vpn,
  output logic             hit,
  output logic [PPN_W-1:0] hit_ppn,
  input  logic             install_en,
  input  logic [PPN_W-1:0] install_vpn,
  input  logic [PPN_W-1:0] install_ppn,
  input  logic             flush
);

  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  tlb_entry_t       entries_q [TLB_ENTRIES];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic [IDX_W-1:0] victim;

  always_comb begin
    hit        = 1'b0;
    hit_ppn    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (entries_q[i].valid && entries_q[i].vpn == lookup_vpn) begin
        hit     = 1'b1;
        hit_ppn = entries_q[i].ppn;
      end
    end
    // Descending scan so the lowest-index free slot wins.
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    victim = free_found ? free_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries_q[i] <= '0;
      ptr_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries_q[i].valid <= 1'b0;
      ptr_q <= '0;
    end else if (install_en) begin
      entries_q[victim] <= '{valid: 1'b1, vpn: install_vpn, ppn: install_ppn};
      if (!free_found) ptr_q <= (ptr_q == LAST_IDX) ? '0 : IDX_W'(ptr_q + 1'b1);
    end
  end

endmodule

// File: rtl/page_walker.sv
// Two-level page-table walk controller in front of a single-port word-addressed ram,
// with a small TLB that lets repeat translations bypass memory.
module page_walker
  import page_walk_pkg::*;
#(
  parameter int TLB_ENTRIES = 4,
  parameter int PRESENT_BIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_va,
  input  logic [31:0] pd_base,
  input  logic        tlb_flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_pa,
  output logic        resp_fault,
  output logic        resp_tlb_hit,
  output logic [29:0] mem_addr,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output pw_state_e   dbg_state
);

  // Handshakes: a request transfers on a cycle with req_valid & req_ready; a response
  // transfers on resp_valid & resp_ready, and resp_* hold steady until it does.

  pw_state_e        state_q, state_d;
  logic [31:0]      va_q;
  logic             flush_seen_q;
  logic             accept;
  logic             present;
  logic             tlb_hit;
  logic [PPN_W-1:0] tlb_ppn;
  logic             install_en;
  logic             unused_bits;

  assign accept      = req_valid && (state_q == IDLE);
  assign present     = mem_rdata[PRESENT_BIT];
  assign unused_bits = ^{pd_base[PAGE_OFF_W-1:0], mem_rdata[PAGE_OFF_W-1:0]};

  // A flush seen at any point during the walk suppresses the install of its result.
  assign install_en = (state_q == PTE_CHK) && present && !flush_seen_q && !tlb_flush;

  pw_tlb #(.TLB_ENTRIES(TLB_ENTRIES)) u_tlb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_vpn  (req_va[VPN_DIR_HI:VPN_TBL_LO]),
    .hit         (tlb_hit),
    .hit_ppn     (tlb_ppn),
    .install_en  (install_en),
    .install_vpn (va_q[VPN_DIR_HI:VPN_TBL_LO]),
    .install_ppn (mem_rdata[31:PAGE_OFF_W]),
    .flush       (tlb_flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = tlb_hit ? RESP : PDE_RD;
      PDE_RD:  state_d = PDE_CHK;
      PDE_CHK: state_d = present ? PTE_RD : RESP;
      PTE_RD:  state_d = PTE_CHK;
      PTE_CHK: state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q         <= '0;
      flush_seen_q <= 1'b0;
      mem_addr     <= '0;
      resp_pa      <= '0;
      resp_fault   <= 1'b0;
      resp_tlb_hit <= 1'b0;
    end else begin
      if (accept)         flush_seen_q <= 1'b0;
      else if (tlb_flush) flush_seen_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            va_q <= req_va;
            if (tlb_hit) begin
              resp_pa      <= {tlb_ppn, req_va[PAGE_OFF_W-1:0]};
              resp_fault   <= 1'b0;
              resp_tlb_hit <= 1'b1;
            end else begin
              // pd_base is consumed here so later changes cannot affect the walk.
              mem_addr     <= {pd_base[31:PAGE_OFF_W], req_va[VPN_DIR_HI:VPN_DIR_LO]};
              resp_pa      <= '0;
              resp_fault   <= 1'b0;
              resp_tlb_hit <= 1'b0;
            end
          end
        end
        PDE_CHK: begin
          if (present) begin
            mem_addr <= {mem_rdata[31:PAGE_OFF_W], va_q[VPN_TBL_HI:VPN_TBL_LO]};
          end else begin
            resp_fault <= 1'b1;
            resp_pa    <= '0;
          end
        end
        PTE_CHK: begin
          if (present) begin
            resp_pa <= {mem_rdata[31:PAGE_OFF_W], va_q[PAGE_OFF_W-1:0]};
          end else begin
            resp_fault <= 1'b1;
            resp_pa    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign mem_read_en  = (state_q == PDE_RD) || (state_q == PTE_RD);
  assign mem_write_en = 1'b0;
  assign busy         = (state_q != IDLE) && (state_q != RESP);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_page_walker.sv
// Directed bench for page_walker: behavioural ram, read-address scoreboard, and
// hand-computed translation results.
module tb_page_walker;
  import page_walk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_va = '0;
  logic [31:0] pd_base = '0;
  logic        tlb_flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_pa;
  logic        resp_fault;
  logic        resp_tlb_hit;
  logic [29:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  pw_state_e   dbg_state;

  logic [31:0] ram [0:2047];
  logic [29:0] exp_q [$];
  logic [29:0] obs_q [$];
  int checks = 0;
  int errors = 0;

  page_walker #(.TLB_ENTRIES(4), .PRESENT_BIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_va(req_va), .pd_base(pd_base), .tlb_flush(tlb_flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pa(resp_pa),
    .resp_fault(resp_fault), .resp_tlb_hit(resp_tlb_hit), .mem_addr(mem_addr),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ram model: data valid the cycle after the read strobe
  always @(posedge clk) if (mem_read_en) mem_rdata <= ram[mem_addr[10:0]];
  always @(posedge clk) if (mem_read_en && rst_n) obs_q.push_back(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: request, bounded wait, response checks, optional hold, drain.
  task automatic txn(input string tag, input logic [31:0] va, input logic [31:0] exp_pa,
                     input logic exp_fault, input logic exp_hit, input int exp_lat,
                     input int flush_at, input int hold, input int n_rd,
                     input logic [29:0] a0, input logic [29:0] a1);
    int lat;
    if (n_rd > 0) exp_q.push_back(a0);
    if (n_rd > 1) exp_q.push_back(a1);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_va    = va;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      tlb_flush = (lat == flush_at);
      @(posedge clk); #1;
      lat++;
    end
    tlb_flush = 1'b0;
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    if (exp_lat != 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_pa"}, resp_pa, exp_pa);
    chk({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
    chk({tag, "_hit"}, 32'(resp_tlb_hit), 32'(exp_hit));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_pa"}, resp_pa, exp_pa);
      chk({tag, "_hold_fault"}, 32'(resp_fault), 32'(exp_fault));
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_drain_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_read_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_read_addr"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    ram[0]    = 32'h0000_1001;
    ram[1024] = 32'h0000_2001;

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_read_en", 32'(mem_read_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_pa", resp_pa, 32'd0);
    chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    txn("miss_walk", 32'h0000_0ABC, 32'h0000_2ABC, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1024);
    txn("hit",       32'h0000_0123, 32'h0000_2123, 0, 1, 1, 0, 0, 0, 30'd0, 30'd0);
    txn("pde_fault", 32'h0040_0000, 32'h0000_0000, 1, 0, 0, 0, 0, 1, 30'd1, 30'd0);
    txn("pte_fault", 32'h0000_1000, 32'h0000_0000, 1, 0, 5, 0, 3, 2, 30'd0, 30'd1025);
    txn("still_hit", 32'h0000_0FFF, 32'h0000_2FFF, 0, 1, 1, 0, 0, 0, 30'd0, 30'd0);
    txn("fault_not_installed", 32'h0000_1000, 32'h0000_0000, 1, 0, 5, 0, 0, 2, 30'd0, 30'd1025);

    // Page i maps to physical page i+2.
    for (int i = 1; i <= 4; i++) ram[1024 + i] = ((i + 2) << 12) | 1;
    txn("fill1", 32'h0000_1010, 32'h0000_3010, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1025);
    txn("fill2", 32'h0000_2000, 32'h0000_4000, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1026);
    txn("fill3", 32'h0000_3000, 32'h0000_5000, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1027);
    txn("fill4_evict0", 32'h0000_4000, 32'h0000_6000, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1028);
    txn("keep1",     32'h0000_1234, 32'h0000_3234, 0, 1, 1, 0, 0, 0, 30'd0, 30'd0);
    txn("evicted0",  32'h0000_0ABC, 32'h0000_2ABC, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1024);
    txn("keep2",     32'h0000_2008, 32'h0000_4008, 0, 1, 1, 0, 0, 0, 30'd0, 30'd0);
    txn("evicted1",  32'h0000_1004, 32'h0000_3004, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1025);

    tlb_flush = 1'b1;
    @(posedge clk); #1;
    tlb_flush = 1'b0;
    txn("flush_miss", 32'h0000_3000, 32'h0000_5000, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1027);
    txn("flush_mid_walk", 32'h0000_4000, 32'h0000_6000, 0, 0, 5, 2, 0, 2, 30'd0, 30'd1028);
    txn("mid_walk_not_installed", 32'h0000_4000, 32'h0000_6000, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1028);

    // Reset while the PTE read is on the bus.
    req_valid = 1'b1;
    req_va    = 32'h0000_2000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pte_rd_read_en", 32'(mem_read_en), 32'd1);
    chk("pte_rd_addr", 32'(mem_addr), 32'd1026);
    rst_n = 1'b0;
    #1;
    chk("async_rst_read_en", 32'(mem_read_en), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    end
    obs_q.delete();
    exp_q.delete();
    txn("post_rst_miss", 32'h0000_4000, 32'h0000_6000, 0, 0, 5, 0, 0, 2, 30'd0, 30'd1028);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
